uart_rx_deframe: RTL and testbench
==================================

Name: uart_rx_deframe

Overview:
- Receive-side UART deframer that sits directly downstream of the rx synchronizer.
- Consumes the already-synchronized serial line and samples each bit at mid-bit using a clock-divider counter.
- Validates start and stop bits and delivers 8-bit bytes to the consumer over a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- BAUD_CLK, 16, clk cycles per serial bit; legal range is 4 or more. Counter width is $clog2(BAUD_CLK). HALF = BAUD_CLK/2, using integer division.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- rx  in  1  serial line, already synchronized to clk (sync-chain output); idle level is 1.
- data  out  8  received byte; held stable while valid=1.
- valid  out  1  data holds an unconsumed byte.
- ready  in  1  consumer accepts data when valid&&ready on a posedge.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: byte completed while the previous byte was unconsumed.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at posedge): state=BREAK, cnt=0, shift=0, data=8'h00, valid=0, frame_err=0, overrun=0. busy=1 because the state is BREAK.
- Reset takes priority over everything; reset mid-frame abandons the frame and produces no valid or error pulse.
- States: IDLE, START, DATA, STOP, BREAK.
- BREAK: wait until rx==1, then go to IDLE. This guarantees a line held low through reset or a break condition never yields a byte.
- IDLE: on rx==0, go to START with cnt=HALF-1. Call this detect cycle t0.
- Counting rule (START/DATA/STOP): if cnt!=0 then cnt--, otherwise sample rx this cycle.
- START sample (t0+HALF):
  - rx==1: false start; go to IDLE with no output.
  - rx==0: go to DATA with cnt=BAUD_CLK-1 and bit index=0.
- DATA sample: shift rx in LSB-first (shift <= {rx, shift[7:1]}) and reload cnt=BAUD_CLK-1.
  - After the 8th sample, go to STOP.
  - Bit i (i=0..7) is sampled at t0+HALF+(i+1)*BAUD_CLK.
- STOP sample (t0+HALF+9*BAUD_CLK):
  - rx==1: frame good; go directly to IDLE, which allows back-to-back frames to resync on the next start edge.
  - rx==0: frame_err=1 for exactly the next cycle; byte discarded; go to BREAK.
- Byte delivery, registered at the STOP-sample edge, so valid is visible one cycle after the sample:
  - If valid==0, or valid&&ready in the same cycle: data<=shift, valid<=1.
  - If valid==1 and ready==0: new byte dropped, data unchanged, overrun=1 for one cycle.
- Handshake:
  - valid&&ready at a posedge with no completing byte: valid<=0.
  - ready while valid==0 has no effect.
  - data never changes while valid==1 except through the simultaneous accept+load above.
- frame_err and overrun are never both asserted, and each is 0 in all other cycles.
- Glitch rejection: a low pulse shorter than HALF cycles is rejected as a false start.

Test Plan:
- Reset with rx=0 held for 100 cycles, then rx=1, BAUD_CLK=16 -> valid, frame_err and overrun stay 0; busy=1 until the cycle after rx rises, then 0.
- Frame 0x55 (start, 1,0,1,0,1,0,1,0, stop=1), ready=1 -> valid=1 in exactly one cycle, 153 cycles after t0, with data=8'h55; no error pulses.
- rx low for 4 cycles then high, BAUD_CLK=16 -> returns to IDLE at t0+8 sample; no valid, no frame_err.
- Frame 0xA3 with stop bit 0 and rx held low for 40 more cycles -> frame_err=1 for one cycle at t0+153; valid stays 0; busy stays 1 until rx returns to 1. A following 0x3C frame is received correctly.
- Frames 0xA3 then 0x3C back-to-back with ready=0 -> data=8'hA3 with valid=1; overrun pulses once at the second stop sample and data stays 8'hA3. Then ready=1 for one cycle -> valid=0.
- Frame 0xFF, reset pulsed at bit 4, then rx=1 and a new 0x81 frame -> no output for the aborted frame; data=8'h81 with valid=1 for the new frame.

Source files
------------

// File: rtl/uart_rx_deframe.sv
// Receive-side UART deframer: mid-bit sampling of an already-synchronized rx line,
// start/stop validation, and byte delivery over a valid/ready handshake.
module uart_rx_deframe #(
    parameter int BAUD_CLK = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(BAUD_CLK);
    localparam int HALF  = BAUD_CLK / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_CLK - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= BREAK;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A consumer accept clears valid unless a new byte lands on the same edge below.
            if (valid && ready)
                valid <= 1'b0;

            case (state)
                BREAK: begin
                    if (rx)
                        state <= IDLE;
                end

                IDLE: begin
                    if (!rx) begin
                        state <= START;
                        cnt   <= CNT_HALF;
                    end
                end

                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx) begin
                        state <= IDLE;
                    end else begin
                        state   <= DATA;
                        cnt     <= CNT_FULL;
                        bit_idx <= 3'd0;
                    end
                end

                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift   <= {rx, shift[7:1]};
                        cnt     <= CNT_FULL;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end

                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx) begin
                        // Straight back to IDLE so a back-to-back start edge is caught.
                        state <= IDLE;
                        if (!valid || ready) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                    end
                end

                default: state <= BREAK;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Bench for uart_rx_deframe: table of frames plus hand-written sequences for break,
// glitch, framing error, overrun and mid-frame reset; accepted bytes checked via a queue.
module tb_uart_rx_deframe;

    localparam int BAUD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_deframe #(.BAUD_CLK(BAUD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int   n_acc = 0, n_ferr = 0, n_ovr = 0;
    int   rise_cyc = -1, ferr_cyc = -1;
    logic prev_valid = 1'b0, prev_acc = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: scoreboard pops on every accepted byte; pulse and hold rules checked as they happen.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            prev_ferr  = 1'b0;
            prev_ovr   = 1'b0;
        end else begin
            if (valid && ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%02h required no byte", data);
                end else begin
                    chk("byte", int'(data), int'(exp_q.pop_front()));
                end
            end
            if (valid && !prev_valid)
                rise_cyc = cyc;
            if (prev_valid && !prev_acc && valid)
                chk("data_hold", int'(data), int'(prev_data));
            if (frame_err || overrun)
                chk("err_exclusive", int'(frame_err & overrun), 0);
            if (frame_err) begin
                n_ferr++;
                ferr_cyc = cyc;
                chk("ferr_single", int'(prev_ferr), 0);
            end
            if (overrun) begin
                n_ovr++;
                chk("ovr_single", int'(prev_ovr), 0);
            end
            prev_valid = valid;
            prev_acc   = valid && ready;
            prev_ferr  = frame_err;
            prev_ovr   = overrun;
            prev_data  = data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives one frame; t_drv is the cycle stamp when rx first goes low.
    // The stop level is held for BAUD+tail cycles before rx returns to idle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int tail,
                              output int t_drv);
        rx    = 1'b0;
        t_drv = cyc;
        ticks(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            ticks(BAUD);
        end
        rx = stop_bit;
        ticks(BAUD + tail);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         n_bytes;
        int         n_err;
    } vec_t;

    vec_t vt[6];

    initial begin
        int t, a0, e0, o0;

        vt[0] = '{8'h55, 1'b1, 1, 0};
        vt[1] = '{8'h00, 1'b1, 1, 0};
        vt[2] = '{8'hFF, 1'b1, 1, 0};
        vt[3] = '{8'hA5, 1'b1, 1, 0};
        vt[4] = '{8'h3C, 1'b1, 1, 0};
        vt[5] = '{8'h80, 1'b0, 0, 1};

        // Reset with the line held low, then release reset while still low.
        rst_n = 1'b0;
        rx    = 1'b0;
        ready = 1'b0;
        ticks(100);
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_busy", int'(busy), 1);
        rst_n = 1'b1;
        ticks(5);
        chk("break_busy", int'(busy), 1);
        chk("break_valid", int'(valid), 0);
        rx = 1'b1;
        tick();
        chk("break_exit_busy", int'(busy), 0);
        ticks(4);
        chk("break_no_err", n_ferr, 0);
        chk("break_no_byte", n_acc, 0);

        // Table of single frames, consumer always ready.
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a0 = n_acc;
            e0 = n_ferr;
            o0 = n_ovr;
            if (vt[i].n_bytes != 0)
                exp_q.push_back(vt[i].b);
            send_frame(vt[i].b, vt[i].stop, 0, t);
            ticks(4);
            chk("tbl_bytes", n_acc - a0, vt[i].n_bytes);
            chk("tbl_ferr", n_ferr - e0, vt[i].n_err);
            chk("tbl_ovr", n_ovr - o0, 0);
            if (vt[i].n_bytes != 0)
                chk("tbl_valid_lat", rise_cyc - t, 153);
            if (vt[i].n_err != 0)
                chk("tbl_ferr_lat", ferr_cyc - t, 153);
            chk("tbl_valid_end", int'(valid), 0);
            chk("tbl_busy_end", int'(busy), 0);
        end

        // Glitch shorter than half a bit.
        a0 = n_acc;
        e0 = n_ferr;
        rx = 1'b0;
        ticks(4);
        rx = 1'b1;
        chk("glitch_busy_mid", int'(busy), 1);
        ticks(10);
        chk("glitch_busy_end", int'(busy), 0);
        chk("glitch_bytes", n_acc - a0, 0);
        chk("glitch_ferr", n_ferr - e0, 0);

        // Framing error with line held low afterwards, then a good frame.
        a0 = n_acc;
        e0 = n_ferr;
        rx = 1'b0;
        t  = cyc;
        ticks(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = 8'hA3 >> i;
            ticks(BAUD);
        end
        rx = 1'b0;
        ticks(BAUD + 40);
        chk("ferr_busy_low", int'(busy), 1);
        chk("ferr_count", n_ferr - e0, 1);
        chk("ferr_lat", ferr_cyc - t, 153);
        chk("ferr_no_byte", n_acc - a0, 0);
        chk("ferr_valid", int'(valid), 0);
        rx = 1'b1;
        tick();
        chk("ferr_busy_release", int'(busy), 0);
        ticks(3);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 0, t);
        ticks(4);
        chk("after_ferr_bytes", n_acc - a0, 1);
        chk("after_ferr_lat", rise_cyc - t, 153);

        // Back-to-back frames with consumer stalled.
        ready = 1'b0;
        a0 = n_acc;
        o0 = n_ovr;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 0, t);
        send_frame(8'h3C, 1'b1, 0, t);
        ticks(4);
        chk("ovr_valid", int'(valid), 1);
        chk("ovr_data", int'(data), 'hA3);
        chk("ovr_count", n_ovr - o0, 1);
        chk("ovr_no_accept", n_acc - a0, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("ovr_drain_valid", int'(valid), 0);
        chk("ovr_drain_bytes", n_acc - a0, 1);
        ticks(4);

        // Reset in the middle of a frame, then a fresh frame.
        ready = 1'b1;
        a0 = n_acc;
        e0 = n_ferr;
        rx = 1'b0;
        ticks(BAUD);
        rx = 1'b1;
        ticks(4 * BAUD + 4);
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(6 * BAUD);
        chk("abort_bytes", n_acc - a0, 0);
        chk("abort_ferr", n_ferr - e0, 0);
        chk("abort_busy", int'(busy), 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 0, t);
        ticks(4);
        chk("abort_new_bytes", n_acc - a0, 1);
        chk("abort_new_lat", rise_cyc - t, 153);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
